route_compute_unit: RTL and testbench

//  Registered, parametrised route computation for one router input port of a DIM_X x DIM_Y mesh.

---
 rtl/noc_route_pkg.sv | 28 ++
 rtl/dor_route_calc.sv | 42 ++++
 rtl/route_compute_unit.sv | 133 +++++++++++++
 tb/tb_route_compute_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_route_pkg.sv
// Shared encodings for the mesh route-compute slice: output ports, flit types,
// routing modes and the per-VC packet state.
package noc_route_pkg;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_EAST  = 3'd1,
    PORT_NORTH = 3'd2,
    PORT_WEST  = 3'd3,
    PORT_SOUTH = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  localparam int unsigned ROUTE_XY = 0;
  localparam int unsigned ROUTE_YX = 1;

  typedef enum logic {
    VC_IDLE = 1'b0,
    VC_BUSY = 1'b1
  } vc_state_e;

endpackage

// File: rtl/dor_route_calc.sv
// Combinational dimension-order route decision for one destination.
// Out-of-mesh destinations are steered to the local port and flagged.
module dor_route_calc
  import noc_route_pkg::*;
#(
  parameter int unsigned DIM_X       = 4,
  parameter int unsigned DIM_Y       = 4,
  parameter int unsigned COORD_WIDTH = 4
) (
  input  logic [COORD_WIDTH-1:0] dx_i,
  input  logic [COORD_WIDTH-1:0] dy_i,
  input  logic [COORD_WIDTH-1:0] x_i,
  input  logic [COORD_WIDTH-1:0] y_i,
  input  logic                   mode_i,
  output port_e                  request_o,
  output logic                   dest_err_o
);

  // One extra bit so a mesh dimension of 2**COORD_WIDTH still compares correctly.
  localparam logic [COORD_WIDTH:0] DIM_X_C = (COORD_WIDTH + 1)'(DIM_X);
  localparam logic [COORD_WIDTH:0] DIM_Y_C = (COORD_WIDTH + 1)'(DIM_Y);

  port_e x_port;
  port_e y_port;

  always_comb begin
    dest_err_o = ({1'b0, dx_i} >= DIM_X_C) || ({1'b0, dy_i} >= DIM_Y_C);

    x_port = PORT_LOCAL;
    if (dx_i > x_i)      x_port = PORT_EAST;
    else if (dx_i < x_i) x_port = PORT_WEST;

    y_port = PORT_LOCAL;
    if (dy_i > y_i)      y_port = PORT_NORTH;
    else if (dy_i < y_i) y_port = PORT_SOUTH;

    if (dest_err_o)  request_o = PORT_LOCAL;
    else if (!mode_i) request_o = (x_port != PORT_LOCAL) ? x_port : y_port;
    else              request_o = (y_port != PORT_LOCAL) ? y_port : x_port;
  end

endmodule

// File: rtl/route_compute_unit.sv
// Route computation for one mesh router input port: decodes head flits, keeps
// the route per VC for body/tail flits, and presents results through a 1-deep stage.
module route_compute_unit
  import noc_route_pkg::*;
#(
  parameter int unsigned DIM_X         = 4,
  parameter int unsigned DIM_Y         = 4,
  parameter int unsigned INDEX         = 5,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PhitPerFlit   = 2,
  parameter int unsigned VC            = 4,
  parameter int unsigned COORD_WIDTH   = 4,
  parameter int unsigned REQUEST_WIDTH = 3,
  parameter int unsigned ROUTING_MODE  = 0,
  localparam int unsigned FLIT_W       = DATA_WIDTH * PhitPerFlit,
  localparam int unsigned VCW          = (VC > 1) ? $clog2(VC) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W-1:0]        in_flit,
  input  logic [VCW-1:0]           in_vc,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [FLIT_W-1:0]        out_flit,
  output logic [VCW-1:0]           out_vc,
  output logic [REQUEST_WIDTH-1:0] out_request,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err_protocol,
  output logic                     err_dest
);

  localparam int unsigned X_POS = INDEX % DIM_X;
  localparam int unsigned Y_POS = INDEX / DIM_X;
  localparam logic [COORD_WIDTH-1:0] X_C = COORD_WIDTH'(X_POS);
  localparam logic [COORD_WIDTH-1:0] Y_C = COORD_WIDTH'(Y_POS);

  vc_state_e vc_state_q [VC];
  port_e     vc_route_q [VC];

  logic [FLIT_W-1:0] out_flit_q;
  logic [VCW-1:0]    out_vc_q;
  port_e             out_request_q;
  logic              out_valid_q;
  logic              err_protocol_q;
  logic              err_dest_q;

  flit_type_e ftype;
  port_e      calc_req;
  logic       calc_err;
  logic       transfer;
  port_e      req_d;
  logic       proto_err_d;
  logic       dest_err_d;

  dor_route_calc #(
    .DIM_X      (DIM_X),
    .DIM_Y      (DIM_Y),
    .COORD_WIDTH(COORD_WIDTH)
  ) u_calc (
    .dx_i      (in_flit[2*COORD_WIDTH-1:COORD_WIDTH]),
    .dy_i      (in_flit[COORD_WIDTH-1:0]),
    .x_i       (X_C),
    .y_i       (Y_C),
    .mode_i    (ROUTING_MODE == ROUTE_YX),
    .request_o (calc_req),
    .dest_err_o(calc_err)
  );

  assign ftype    = flit_type_e'(in_flit[FLIT_W-1:FLIT_W-2]);
  assign in_ready = !out_valid_q || out_ready;
  assign transfer = in_valid && in_ready;

  // Protocol violations still forward the flit; only the request is affected.
  always_comb begin
    req_d       = PORT_LOCAL;
    proto_err_d = 1'b0;
    dest_err_d  = 1'b0;
    unique case (ftype)
      FT_HEAD: begin
        req_d       = calc_req;
        dest_err_d  = calc_err;
        proto_err_d = (vc_state_q[in_vc] == VC_BUSY);
      end
      FT_SINGLE: begin
        req_d      = calc_req;
        dest_err_d = calc_err;
      end
      default: begin
        if (vc_state_q[in_vc] == VC_BUSY) req_d = vc_route_q[in_vc];
        else                              proto_err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q    <= 1'b0;
      out_flit_q     <= '0;
      out_vc_q       <= '0;
      out_request_q  <= PORT_LOCAL;
      err_protocol_q <= 1'b0;
      err_dest_q     <= 1'b0;
      for (int unsigned i = 0; i < VC; i++) begin
        vc_state_q[i] <= VC_IDLE;
        vc_route_q[i] <= PORT_LOCAL;
      end
    end else if (transfer) begin
      out_valid_q   <= 1'b1;
      out_flit_q    <= in_flit;
      out_vc_q      <= in_vc;
      out_request_q <= req_d;
      if (proto_err_d) err_protocol_q <= 1'b1;
      if (dest_err_d)  err_dest_q     <= 1'b1;
      if (ftype == FT_HEAD) begin
        vc_state_q[in_vc] <= VC_BUSY;
        vc_route_q[in_vc] <= calc_req;
      end else if (ftype == FT_TAIL) begin
        vc_state_q[in_vc] <= VC_IDLE;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_flit     = out_flit_q;
  assign out_vc       = out_vc_q;
  assign out_request  = REQUEST_WIDTH'(out_request_q);
  assign out_valid    = out_valid_q;
  assign err_protocol = err_protocol_q;
  assign err_dest     = err_dest_q;

endmodule

// File: tb/tb_route_compute_unit.sv
// Scoreboard bench for route_compute_unit: one XY and one YX instance share the
// same stimulus; a reference model predicts outputs, a monitor pops and compares.
module tb_route_compute_unit;
  import noc_route_pkg::*;

  localparam int NX = 4;
  localparam int NY = 4;
  localparam int MX = 1;
  localparam int MY = 1;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [FW-1:0] in_flit = '0;
  logic [1:0]    in_vc = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;

  logic          ir_xy, ir_yx, ov_xy, ov_yx, ep_xy, ep_yx, ed_xy, ed_yx;
  logic [FW-1:0] of_xy, of_yx;
  logic [1:0]    ovc_xy, ovc_yx;
  logic [2:0]    rq_xy, rq_yx;

  always #5 clk = ~clk;

  route_compute_unit #(.ROUTING_MODE(0)) dut_xy (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_vc(in_vc), .in_valid(in_valid),
    .in_ready(ir_xy), .out_flit(of_xy), .out_vc(ovc_xy), .out_request(rq_xy),
    .out_valid(ov_xy), .out_ready(out_ready), .err_protocol(ep_xy), .err_dest(ed_xy)
  );

  route_compute_unit #(.ROUTING_MODE(1)) dut_yx (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_vc(in_vc), .in_valid(in_valid),
    .in_ready(ir_yx), .out_flit(of_yx), .out_vc(ovc_yx), .out_request(rq_yx),
    .out_valid(ov_yx), .out_ready(out_ready), .err_protocol(ep_yx), .err_dest(ed_yx)
  );

  typedef struct {
    logic [FW-1:0] flit;
    int            vc;
    int            rxy;
    int            ryx;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit busy[4];
  int rt_xy[4];
  int rt_yx[4];
  bit cur_ov, nxt_ov, cur_ep, nxt_ep, cur_ed, nxt_ed, exp_ir;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int route(input int dx, input int dy, input bit yx);
    int xp, yp;
    if (dx >= NX || dy >= NY) return 0;
    xp = (dx > MX) ? 1 : (dx < MX) ? 3 : 0;
    yp = (dy > MY) ? 2 : (dy < MY) ? 4 : 0;
    if (!yx) return (xp != 0) ? xp : yp;
    return (yp != 0) ? yp : xp;
  endfunction

  // One clock of stimulus; the model is updated only for flits that will be accepted.
  task automatic cycle(input bit iv, input logic [1:0] ft, input int vc,
                       input int dx, input int dy, input bit ordy);
    exp_t e;
    @(posedge clk);
    #1;
    cur_ov = nxt_ov; cur_ep = nxt_ep; cur_ed = nxt_ed;
    in_flit   = {ft, 6'($urandom), 4'(dx), 4'(dy)};
    in_vc     = 2'(vc);
    in_valid  = iv;
    out_ready = ordy;
    exp_ir    = !cur_ov || ordy;
    chk_en    = 1'b1;
    if (iv && exp_ir) begin
      e.flit = in_flit;
      e.vc   = vc;
      e.rxy  = 0;
      e.ryx  = 0;
      case (ft)
        2'b01: begin
          if (busy[vc]) nxt_ep = 1'b1;
          busy[vc]  = 1'b1;
          rt_xy[vc] = route(dx, dy, 1'b0);
          rt_yx[vc] = route(dx, dy, 1'b1);
          e.rxy = rt_xy[vc];
          e.ryx = rt_yx[vc];
          if (dx >= NX || dy >= NY) nxt_ed = 1'b1;
        end
        2'b11: begin
          e.rxy = route(dx, dy, 1'b0);
          e.ryx = route(dx, dy, 1'b1);
          if (dx >= NX || dy >= NY) nxt_ed = 1'b1;
        end
        default: begin
          if (busy[vc]) begin
            e.rxy = rt_xy[vc];
            e.ryx = rt_yx[vc];
          end else begin
            nxt_ep = 1'b1;
          end
          if (ft == 2'b10) busy[vc] = 1'b0;
        end
      endcase
      sb.push_back(e);
      nxt_ov = 1'b1;
    end else if (ordy) begin
      nxt_ov = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    chk_en   = 1'b0;
    rst      = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      busy[i] = 1'b0; rt_xy[i] = 0; rt_yx[i] = 0;
    end
    cur_ov = 0; nxt_ov = 0; cur_ep = 0; nxt_ep = 0; cur_ed = 0; nxt_ed = 0;
    #2;
    check("rst_out_valid", {ov_yx, ov_xy}, 32'd0);
    check("rst_out_flit", {of_yx, of_xy}, 32'd0);
    check("rst_out_vc_req", {ovc_yx, ovc_xy, rq_yx, rq_xy}, 32'd0);
    check("rst_err", {ep_yx, ep_xy, ed_yx, ed_xy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_en && rst) begin
      check("in_ready_xy", ir_xy, exp_ir);
      check("in_ready_yx", ir_yx, exp_ir);
      check("out_valid", {ov_yx, ov_xy}, {cur_ov, cur_ov});
      check("err_protocol", {ep_yx, ep_xy}, {cur_ep, cur_ep});
      check("err_dest", {ed_yx, ed_xy}, {cur_ed, cur_ed});
      if (ov_xy && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_flit_xy", of_xy, e.flit);
          check("out_flit_yx", of_yx, e.flit);
          check("out_vc", {ovc_yx, ovc_xy}, {2'(e.vc), 2'(e.vc)});
          check("req_xy", rq_xy, e.rxy);
          check("req_yx", rq_yx, e.ryx);
        end
      end
    end
  end

  initial begin
    int vc, dx, dy;
    logic [1:0] ft;
    do_reset();

    // Single flit to (3,0): XY -> east, YX -> south.
    cycle(1, FT_SINGLE, 0, 3, 0, 1);
    cycle(0, FT_BODY, 0, 0, 0, 1);

    // Packet on VC2 towards (1,3): every flit requests north.
    cycle(1, FT_HEAD, 2, 1, 3, 1);
    cycle(1, FT_BODY, 2, 0, 0, 1);
    cycle(1, FT_BODY, 2, 0, 0, 1);
    cycle(1, FT_TAIL, 2, 0, 0, 1);
    cycle(1, FT_HEAD, 2, 2, 2, 1);
    cycle(1, FT_TAIL, 2, 0, 0, 1);

    // Interleaved packets on VC0 (west) and VC1 (east).
    cycle(1, FT_HEAD, 0, 0, 1, 1);
    cycle(1, FT_HEAD, 1, 2, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, FT_BODY, 0, 0, 0, 1);
      cycle(1, FT_BODY, 1, 0, 0, 1);
    end
    cycle(1, FT_TAIL, 0, 0, 0, 1);
    cycle(1, FT_TAIL, 1, 0, 0, 1);

    // Backpressure for 5 cycles with a flit waiting.
    cycle(1, FT_HEAD, 3, 3, 3, 0);
    for (int i = 0; i < 5; i++) cycle(1, FT_BODY, 3, 0, 0, 0);
    cycle(1, FT_BODY, 3, 0, 0, 1);
    cycle(1, FT_TAIL, 3, 0, 0, 1);
    cycle(0, FT_BODY, 0, 0, 0, 1);

    // Body on idle VC3, then out-of-mesh destination.
    cycle(1, FT_BODY, 3, 0, 0, 1);
    cycle(1, FT_HEAD, 0, 7, 0, 1);
    cycle(1, FT_TAIL, 0, 0, 0, 1);
    cycle(0, FT_BODY, 0, 0, 0, 1);

    // Reset in the middle of a VC1 packet, then continue it illegally.
    do_reset();
    cycle(1, FT_HEAD, 1, 3, 3, 0);
    cycle(1, FT_BODY, 1, 0, 0, 0);
    do_reset();
    cycle(1, FT_BODY, 1, 0, 0, 1);
    cycle(0, FT_BODY, 0, 0, 0, 1);

    do_reset();
    for (int i = 0; i < 800; i++) begin
      vc = int'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 3)  ft = 2'($urandom);
      else if (busy[vc])              ft = ($urandom_range(0, 2) == 0) ? FT_TAIL : FT_BODY;
      else                            ft = ($urandom_range(0, 3) == 0) ? FT_SINGLE : FT_HEAD;
      if ($urandom_range(0, 99) < 5) begin
        dx = int'($urandom_range(0, 15)); dy = int'($urandom_range(0, 15));
      end else begin
        dx = int'($urandom_range(0, NX - 1)); dy = int'($urandom_range(0, NY - 1));
      end
      cycle($urandom_range(0, 3) != 0, ft, vc, dx, dy, $urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 4; i++) cycle(0, FT_BODY, 0, 0, 0, 1);
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
